dec_onehot_seq: RTL and testbench

- Parametrised N-to-2^N one-hot decoder with registered outputs and three operating modes.
- DIRECT: registered decode of a select input.
- SCAN: automatic rotating strobe with programmable dwell, for row/column drive of matrix peripherals.
- PULSE: one-shot strobe of programmable length.
- Generalises the combinational 4-to-16 decoder to any select width, with output polarity control and sequencing.

---
 rtl/dec_pkg.sv | 16 +
 rtl/dec_onehot_n.sv | 15 +
 rtl/dec_onehot_seq.sv | 149 ++++++++++++++
 tb/tb_dec_onehot_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - mode and state encodings shared by the one-hot sequencer
package dec_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_PULSE  = 2'd3
  } state_e;

endpackage

// File: rtl/dec_onehot_n.sv
// rtl/dec_onehot_n.sv - combinational N-bit index to 2**N one-hot decode
module dec_onehot_n #(
  parameter int N = 4
) (
  input  logic [N-1:0]    idx_i,
  output logic [2**N-1:0] onehot_o
);

  // Single asserted bit at the position named by the index
  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// rtl/dec_onehot_seq.sv - registered one-hot decoder with direct, scan and pulse modes
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    sel,
  input  logic            load,
  input  logic [DW-1:0]   dwell,
  output logic [2**N-1:0] y,
  output logic [N-1:0]    idx,
  output logic            active,
  output logic            busy,
  output logic            wrap,
  output logic            done
);

  localparam int OUTS = 2**N;
  localparam logic [OUTS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [OUTS-1:0] y_q, y_d;
  logic            active_q, busy_q, wrap_q, done_q;
  logic            show_d, busy_d, wrap_d, done_d;
  logic            abort;
  logic [OUTS-1:0] onehot;

  // The decode works on the next index so y lands in the same register stage as idx
  dec_onehot_n #(.N(N)) u_decode (
    .idx_i    (idx_d),
    .onehot_o (onehot)
  );

  assign abort = !en || (mode == MODE_RSVD);

  // Next state, index, counter and strobe flags; anything not held falls back to IDLE
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    show_d  = 1'b0;
    busy_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort) begin
          case (mode)
            MODE_DIRECT: begin
              state_d = ST_DIRECT;
              idx_d   = sel;
              show_d  = 1'b1;
            end
            MODE_SCAN: begin
              state_d = ST_SCAN;
              idx_d   = sel;
              cnt_d   = dwell;
              show_d  = 1'b1;
            end
            MODE_PULSE: begin
              if (load) begin
                state_d = ST_PULSE;
                idx_d   = sel;
                cnt_d   = dwell;
                show_d  = 1'b1;
                busy_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DIRECT: begin
        if (en && mode == MODE_DIRECT) begin
          state_d = ST_DIRECT;
          idx_d   = sel;
          show_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (en && mode == MODE_SCAN) begin
          state_d = ST_SCAN;
          show_d  = 1'b1;
          if (cnt_q == '0) begin
            idx_d  = idx_q + 1'b1;
            cnt_d  = dwell;
            wrap_d = &idx_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_PULSE: begin
        // A mode change or disable abandons the pulse silently; only a natural end flags done
        if (en && mode == MODE_PULSE) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = cnt_q - 1'b1;
            show_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
    y_d = show_d ? (onehot ^ INACTIVE) : INACTIVE;
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      y_q      <= INACTIVE;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      active_q <= show_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign y      = y_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// tb/tb_dec_onehot_seq.sv - scoreboard bench for the one-hot sequencer
module tb_dec_onehot_seq;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic [7:0]  dwell;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        active, busy, wrap, done;

  logic [2:0]  b_sel;
  logic [3:0]  b_dwell;
  logic [7:0]  b_y;
  logic [2:0]  b_idx;
  logic        b_active, b_busy, b_wrap, b_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        ci;
    logic        act, bsy, wrp, dn;
  } exp_t;

  exp_t sbq[$];

  dec_onehot_seq #(.N(4), .DW(8), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load), .dwell(dwell),
    .y(y), .idx(idx), .active(active), .busy(busy), .wrap(wrap), .done(done)
  );

  dec_onehot_seq #(.N(3), .DW(4), .ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(b_sel), .load(load), .dwell(b_dwell),
    .y(b_y), .idx(b_idx), .active(b_active), .busy(b_busy), .wrap(b_wrap), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the inputs just driven, then compare after the next edge
  task automatic cyc(input string tag, input logic [15:0] ey, input logic [3:0] ei,
                     input logic ci, input logic eb, input logic ew, input logic ed);
    exp_t e;
    e.tag = tag; e.y = ey; e.idx = ei; e.ci = ci;
    e.act = (ey != 16'h0); e.bsy = eb; e.wrp = ew; e.dn = ed;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".y"}, 32'(y), 32'(e.y));
    if (e.ci) chk({e.tag, ".idx"}, 32'(idx), 32'(e.idx));
    chk({e.tag, ".active"}, 32'(active), 32'(e.act));
    chk({e.tag, ".busy"}, 32'(busy), 32'(e.bsy));
    chk({e.tag, ".wrap"}, 32'(wrap), 32'(e.wrp));
    chk({e.tag, ".done"}, 32'(done), 32'(e.dn));
  endtask

  initial begin
    logic [15:0] one;
    logic [3:0]  ei;
    one = 16'h0001;
    rst = 1'b1; en = 1'b0; mode = 2'b00; sel = 4'd0; load = 1'b0; dwell = 8'd0;
    b_sel = 3'd0; b_dwell = 4'd0;

    #3;
    chk("reset.y", 32'(y), 32'h0);
    chk("reset.idx", 32'(idx), 32'h0);
    chk("reset.flags", {28'h0, active, busy, wrap, done}, 32'h0);
    chk("reset_lo.y", 32'(b_y), 32'hFF);
    chk("reset_lo.active", 32'(b_active), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // DIRECT
    en = 1'b1; mode = 2'b00; sel = 4'd5; b_sel = 3'd0;
    cyc("dir5", 16'h0020, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dir_lo0.y", 32'(b_y), 32'hFE);
    chk("dir_lo0.active", 32'(b_active), 32'h1);
    sel = 4'd15; b_sel = 3'd7;
    cyc("dir15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("dir_lo7.y", 32'(b_y), 32'h7F);

    // SCAN with dwell=2 from 14, crossing the wrap; mode change passes through IDLE
    mode = 2'b01; sel = 4'd14; dwell = 8'd2;
    cyc("scan_gap", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      ei = 4'(14 + k / 3);
      cyc("scan_wrap", one << ei, ei, 1'b1, 1'b0, (k == 6), 1'b0);
    end
    for (int k = 0; k < 7; k++) begin
      ei = 4'(1 + k / 3);
      cyc("scan_run", one << ei, ei, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Abort at idx 3, then restart from a new sel
    en = 1'b0;
    cyc("abort", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1; sel = 4'd10;
    cyc("restart", 16'h0400, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("restart_hold", 16'h0400, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);

    // dwell=0 advances every cycle
    en = 1'b0;
    cyc("idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1; sel = 4'd15; dwell = 8'd0;
    cyc("d0_15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("d0_wrap", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      ei = 4'(k);
      cyc("d0_run", one << ei, ei, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-scan at idx 7, observed before any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.y", 32'(y), 32'h0);
    chk("async_rst.idx", 32'(idx), 32'h0);
    chk("async_rst.wrap", 32'(wrap), 32'h0);
    chk("async_rst.active", 32'(active), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // PULSE of 4 cycles; a load while busy must not extend it
    mode = 2'b10; sel = 4'd9; dwell = 8'd3; load = 1'b1;
    cyc("p1", 16'h0200, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc("p2", 16'h0200, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    load = 1'b1;
    cyc("p3_reload", 16'h0200, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc("p4", 16'h0200, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("p_done", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Load in the done cycle starts the next pulse
    load = 1'b1; sel = 4'd3; dwell = 8'd0;
    cyc("p2_start", 16'h0008, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    cyc("p2_done", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("p_idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reserved mode behaves as IDLE
    mode = 2'b00; sel = 4'd2;
    cyc("dir2", 16'h0004, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    mode = 2'b11;
    cyc("rsvd", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rsvd_lo.y", 32'(b_y), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
